// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging one burst at a time onto a single-port, byte-writable SRAM macro.
// Optional response checking (SLVERR on bad size / WLAST) is built when AXI_SLV_ERRCHK_EN is defined.
module axi_sram_slave #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int MEM_AW    = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ID_BITS-1:0]     AWID,
    input  logic [ADDR_BITS-1:0]   AWADDR,
    input  logic [LEN_BITS-1:0]    AWLEN,
    input  logic [2:0]             AWSIZE,
    input  logic [1:0]             AWBURST,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [DATA_BITS-1:0]   WDATA,
    input  logic [DATA_BITS/8-1:0] WSTRB,
    input  logic                   WLAST,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [ID_BITS-1:0]     BID,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [ID_BITS-1:0]     ARID,
    input  logic [ADDR_BITS-1:0]   ARADDR,
    input  logic [LEN_BITS-1:0]    ARLEN,
    input  logic [2:0]             ARSIZE,
    input  logic [1:0]             ARBURST,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [ID_BITS-1:0]     RID,
    output logic [DATA_BITS-1:0]   RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic                   sram_cs,
    output logic [DATA_BITS/8-1:0] sram_we,
    output logic [MEM_AW-1:0]      sram_addr,
    output logic [DATA_BITS-1:0]   sram_din,
    input  logic [DATA_BITS-1:0]   sram_dout
);

    typedef enum logic [2:0] {IDLE, W_DATA, B_RESP, R_FETCH, R_DATA} state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic [LEN_BITS-1:0]  cnt_q, cnt_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ID_BITS-1:0]   id_q, id_d;
    logic [1:0]           burst_q, burst_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 fresh_q, fresh_d;

    logic                 aw_rdy, ar_rdy, last;
    logic [ADDR_BITS-1:0] addr_next;

    // prio=1 lets a pending read win a tie right after a write burst
    assign aw_rdy = rst & (state_q == IDLE) & AWVALID & (~ARVALID | ~prio_q);
    assign ar_rdy = rst & (state_q == IDLE) & ARVALID & ~aw_rdy;
    assign AWREADY = aw_rdy;
    assign ARREADY = ar_rdy;

    assign last      = (cnt_q == len_q);
    assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_BITS'(4);
    assign sram_addr = addr_q[MEM_AW+1:2];

    assign BID   = id_q;
    assign RID   = id_q;
    assign RLAST = (state_q == R_DATA) & last;
    // first R_DATA cycle forwards the macro output, later cycles replay the captured word
    assign RDATA = fresh_q ? sram_dout : rdata_q;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        addr_d   = addr_q;
        id_d     = id_q;
        burst_d  = burst_q;
        fresh_d  = (state_q == R_FETCH);
        rdata_d  = fresh_q ? sram_dout : rdata_q;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        RVALID   = 1'b0;
        sram_cs  = 1'b0;
        sram_we  = '0;
        sram_din = '0;
        case (state_q)
            IDLE: begin
                if (aw_rdy) begin
                    id_d    = AWID;
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    burst_d = AWBURST;
                    cnt_d   = '0;
                    state_d = W_DATA;
                end else if (ar_rdy) begin
                    id_d    = ARID;
                    addr_d  = ARADDR;
                    len_d   = ARLEN;
                    burst_d = ARBURST;
                    cnt_d   = '0;
                    state_d = R_FETCH;
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    sram_cs  = 1'b1;
                    sram_we  = WSTRB;
                    sram_din = WDATA;
                    addr_d   = addr_next;
                    if (last) state_d = B_RESP;
                    else      cnt_d   = cnt_q + 1'b1;
                end
            end
            B_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    prio_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            R_FETCH: begin
                sram_cs = 1'b1;
                state_d = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    if (last) begin
                        prio_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = R_FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            id_q    <= '0;
            burst_q <= '0;
            rdata_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            burst_q <= burst_d;
            rdata_q <= rdata_d;
            fresh_q <= fresh_d;
        end
    end

`ifdef AXI_SLV_ERRCHK_EN
    // sticky per-burst error; seeded by the size check at the address handshake
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (aw_rdy)
            err_d = (AWSIZE != 3'b010);
        else if (ar_rdy)
            err_d = (ARSIZE != 3'b010);
        else if (state_q == W_DATA && WVALID && (WLAST != last))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign BRESP = err_q ? 2'b10 : 2'b00;
    assign RRESP = err_q ? 2'b10 : 2'b00;
`else
    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE, ARSIZE, WLAST};
    assign BRESP = 2'b00;
    assign RRESP = 2'b00;
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: transaction-level memory model, queued expectations
// checked every cycle by one monitor, plus literal checks on latency, arbitration and reset.
module tb_axi_sram_slave;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
`ifdef AXI_SLV_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        sram_cs;
    logic [3:0]  sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_din, sram_dout;

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM macro: registered read data, byte-enabled write
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we == 4'b0000) sram_dout <= mem[sram_addr];
            else                    mem[sram_addr] <= merge(mem[sram_addr], sram_din, sram_we);
        end
    end

    typedef struct packed { logic [13:0] a; logic [3:0] we; logic [31:0] d; } w_exp_t;
    typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [7:0] id; logic [31:0] d; logic last; logic [1:0] resp; } r_exp_t;

    w_exp_t wq[$];
    b_exp_t bq[$];
    r_exp_t rq[$];
    logic [31:0] ref_mem [0:16383];
    int n_chk = 0, n_fail = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_bresp;
    int          last_grant_wait;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", nm, $time);
    endtask

    function automatic logic [1:0] exp_resp(input logic bad);
        return (ERRCHK && bad) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == FIXED) ? a : a + 32'(4 * i);
    endfunction

    // Transaction-level model: memory image plus queued expectations
    task automatic model_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [2:0] size,
                               input logic [31:0] dbase, input logic [3:0] strb, input int early);
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, i);
            ref_mem[a[15:2]] = merge(ref_mem[a[15:2]], dbase + 32'(i), strb);
            wq.push_back('{a: a[15:2], we: strb, d: dbase + 32'(i)});
        end
        bq.push_back('{id: id, resp: exp_resp(size != 3'b010 || (early >= 0 && early != int'(len)))});
    endtask

    task automatic model_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, i);
            rq.push_back('{id: id, d: ref_mem[a[15:2]], last: (i == int'(len)), resp: exp_resp(size != 3'b010)});
        end
    endtask

    // Monitor: every cycle an output is meaningful it must match the queue head
    always @(negedge clk) begin
        if (rst) begin
            if (sram_cs && sram_we != 4'b0000) begin
                if (wq.size() == 0) fail_now("sram_write_unexpected");
                else begin
                    check("sram_addr", 64'(sram_addr), 64'(wq[0].a));
                    check("sram_we", 64'(sram_we), 64'(wq[0].we));
                    check("sram_din", 64'(sram_din), 64'(wq[0].d));
                    void'(wq.pop_front());
                end
            end
            if (BVALID) begin
                if (bq.size() == 0) fail_now("b_unexpected");
                else begin
                    check("bid", 64'(BID), 64'(bq[0].id));
                    check("bresp", 64'(BRESP), 64'(bq[0].resp));
                    if (BREADY) void'(bq.pop_front());
                end
            end
            if (RVALID) begin
                if (rq.size() == 0) fail_now("r_unexpected");
                else begin
                    check("rdata", 64'(RDATA), 64'(rq[0].d));
                    check("rid", 64'(RID), 64'(rq[0].id));
                    check("rlast", 64'(RLAST), 64'(rq[0].last));
                    check("rresp", 64'(RRESP), 64'(rq[0].resp));
                    if (RREADY) void'(rq.pop_front());
                end
            end
        end
    end

    task automatic send_w(input logic [3:0] len, input logic [31:0] dbase, input logic [3:0] strb,
                          input int early);
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b1;
            WDATA  = dbase + 32'(i);
            WSTRB  = strb;
            WLAST  = (i == int'(len)) || (i == early);
            @(negedge clk);
            check("wready", 64'(WREADY), 64'd1);
            @(posedge clk); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        do begin @(negedge clk); n++; end while (!BVALID && n < 50);
        if (!BVALID) begin fail_now("b_timeout"); return; end
        check("b_latency", 64'(n), 64'd1);
        last_bresp = BRESP;
        @(posedge clk); #1;
    endtask

    task automatic recv_r(input logic [3:0] len, input int stall_beat, input int stall_n);
        int n;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == stall_beat) RREADY = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!RVALID && n < 50);
            if (!RVALID) begin fail_now("r_timeout"); RREADY = 1'b1; return; end
            check(b == 0 ? "r_first_latency" : "r_beat_gap", 64'(n), 64'd2);
            if (b == stall_beat) begin
                repeat (stall_n) @(posedge clk);
                #1 RREADY = 1'b1;
                @(negedge clk);
            end
            last_rdata = RDATA;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [31:0] dbase, input logic [3:0] strb, input int early);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size; AWVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
        if (!AWREADY) begin fail_now("aw_grant_timeout"); AWVALID = 1'b0; return; end
        model_write(id, addr, len, burst, size, dbase, strb, early);
        @(posedge clk); #1 AWVALID = 1'b0;
        send_w(len, dbase, strb, early);
        wait_b();
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int stall_beat, input int stall_n);
        int n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size; ARVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
        last_grant_wait = n;
        if (!ARREADY) begin fail_now("ar_grant_timeout"); ARVALID = 1'b0; return; end
        model_read(id, addr, len, burst, size);
        @(posedge clk); #1 ARVALID = 1'b0;
        recv_r(len, stall_beat, stall_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
        rst = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;
        // T3 setup: both address channels valid while still in reset
        AWID = 8'h33; AWADDR = 32'h200; AWLEN = 4'd1; AWBURST = INCR; AWSIZE = 3'b010; AWVALID = 1'b1;
        ARID = 8'h44; ARADDR = 32'h200; ARLEN = 4'd1; ARBURST = INCR; ARSIZE = 3'b010; ARVALID = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_wready", 64'(WREADY), 64'd0);
        check("rst_bvalid", 64'(BVALID), 64'd0);
        check("rst_rvalid", 64'(RVALID), 64'd0);
        check("rst_sram_cs", 64'(sram_cs), 64'd0);
        check("rst_sram_we", 64'(sram_we), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // T3: tie after reset -> write; tie after a write -> read; tie after a read -> write
        @(negedge clk);
        check("t3_tie_write_first", 64'({AWREADY, ARREADY}), 64'b10);
        model_write(8'h33, 32'h200, 4'd1, INCR, 3'b010, 32'hD0, 4'hF, -1);
        @(posedge clk); #1 AWVALID = 1'b0;
        send_w(4'd1, 32'hD0, 4'hF, -1);
        AWID = 8'h55; AWADDR = 32'h300; AWLEN = 4'd0; AWBURST = INCR; AWSIZE = 3'b010; AWVALID = 1'b1;
        wait_b();
        @(negedge clk);
        check("t3_tie_read_next", 64'({AWREADY, ARREADY}), 64'b01);
        model_read(8'h44, 32'h200, 4'd1, INCR, 3'b010);
        @(posedge clk); #1 ARVALID = 1'b0;
        recv_r(4'd1, -1, 0);
        check("t3_read_word1", 64'(last_rdata), 64'hD1);
        ARID = 8'h66; ARADDR = 32'h300; ARLEN = 4'd0; ARBURST = INCR; ARSIZE = 3'b010; ARVALID = 1'b1;
        @(negedge clk);
        check("t3_tie_write_again", 64'({AWREADY, ARREADY}), 64'b10);
        model_write(8'h55, 32'h300, 4'd0, INCR, 3'b010, 32'hE0, 4'hF, -1);
        @(posedge clk); #1 AWVALID = 1'b0;
        send_w(4'd0, 32'hE0, 4'hF, -1);
        wait_b();
        do_read(8'h66, 32'h300, 4'd0, INCR, 3'b010, -1, 0);
        check("t3_read_e0", 64'(last_rdata), 64'hE0);

        // T1 / T2: INCR burst write then read-back with a 3-cycle RREADY stall on beat 2
        do_write(8'h11, 32'h100, 4'd3, INCR, 3'b010, 32'hA0, 4'hF, -1);
        check("t1_mem_0x40", 64'(mem[14'h40]), 64'hA0);
        check("t1_mem_0x43", 64'(mem[14'h43]), 64'hA3);
        check("t1_bresp", 64'(last_bresp), 64'd0);
        do_read(8'h22, 32'h100, 4'd3, INCR, 3'b010, 1, 3);
        check("t2_last_rdata", 64'(last_rdata), 64'hA3);

        // T4: partial strobes and FIXED burst
        do_write(8'h77, 32'h400, 4'd0, INCR, 3'b010, 32'h12345678, 4'hF, -1);
        do_write(8'h77, 32'h400, 4'd0, INCR, 3'b010, 32'hFFFFFFFF, 4'b0101, -1);
        do_read(8'h78, 32'h400, 4'd0, INCR, 3'b010, -1, 0);
        check("t4_strobe_merge", 64'(last_rdata), 64'h12FF56FF);
        do_write(8'h79, 32'h500, 4'd2, FIXED, 3'b010, 32'hB0, 4'hF, -1);
        check("t4_fixed_mem", 64'(mem[14'h140]), 64'hB2);
        check("t4_fixed_next_word", 64'(mem[14'h141]), 64'h0);
        do_read(8'h7A, 32'h500, 4'd2, FIXED, 3'b010, -1, 0);
        check("t4_fixed_read", 64'(last_rdata), 64'hB2);

        // Address wrap at 2^32, aliasing above the SRAM range, WRAP served as INCR
        do_write(8'h80, 32'hFFFF_FFFC, 4'd1, INCR, 3'b010, 32'hC8, 4'hF, -1);
        check("wrap_mem_top", 64'(mem[14'h3FFF]), 64'hC8);
        check("wrap_mem_zero", 64'(mem[14'h0]), 64'hC9);
        do_read(8'h81, 32'h0000_FFFC, 4'd1, WRAP, 3'b010, -1, 0);
        check("alias_read", 64'(last_rdata), 64'hC9);

        // Non-word sizes: data still served, response depends on the checker build
        do_read(8'h82, 32'h100, 4'd0, INCR, 3'b000, -1, 0);
        do_write(8'h91, 32'h800, 4'd0, INCR, 3'b001, 32'h5A5A5A5A, 4'hF, -1);
        check("size_bresp", 64'(last_bresp), ERRCHK ? 64'd2 : 64'd0);

        // T6: early WLAST on beat 0 of a 2-beat burst
        do_write(8'h90, 32'h700, 4'd1, INCR, 3'b010, 32'hF0, 4'hF, 0);
        check("t6_bresp", 64'(last_bresp), ERRCHK ? 64'd2 : 64'd0);
        check("t6_beat0_written", 64'(mem[14'h1C0]), 64'hF0);
        check("t6_beat1_written", 64'(mem[14'h1C1]), 64'hF1);

        // T5: asynchronous reset while a read beat is presented
        ARID = 8'hA5; ARADDR = 32'h100; ARLEN = 4'd3; ARBURST = INCR; ARSIZE = 3'b010; ARVALID = 1'b1;
        @(negedge clk);
        if (!ARREADY) fail_now("t5_ar_grant");
        model_read(8'hA5, 32'h100, 4'd3, INCR, 3'b010);
        @(posedge clk); #1 ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rvalid_before", 64'(RVALID), 64'd1);
        #2 rst = 1'b0;
        ARID = 8'hB5; ARADDR = 32'h100; ARLEN = 4'd0; ARVALID = 1'b1;
        #1;
        check("t5_rvalid_drop", 64'(RVALID), 64'd0);
        check("t5_arready_gated", 64'(ARREADY), 64'd0);
        check("t5_sram_cs_drop", 64'(sram_cs), 64'd0);
        rq.delete();
        RREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_read(8'hB5, 32'h100, 4'd0, INCR, 3'b010, -1, 0);
        check("t5_grant_after_reset", 64'(last_grant_wait), 64'd1);
        check("t5_read_after_reset", 64'(last_rdata), 64'hA0);

        repeat (3) @(negedge clk);
        check("end_w_queue_empty", 64'(wq.size()), 64'd0);
        check("end_b_queue_empty", 64'(bq.size()), 64'd0);
        check("end_r_queue_empty", 64'(rq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
